// File: rtl/hazard_unit.sv
// Pipeline hazard unit: single-cycle load-use stall, branch flush and registered EX operand selects.
// Build option: define HAZARD_PERF_EN to add the saturating stall_cnt output.
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_wen,
    input  logic        id_is_load,
    input  logic        id_a_pc,
    input  logic        id_b_imm,
    input  logic        br_taken,
    output logic        A1_sel,
    output logic        A2_sel,
    output logic        B1_sel,
    output logic        B2_sel,
    output logic        stall,
    output logic        flush,
`ifdef HAZARD_PERF_EN
    output logic        ex_valid,
    output logic [31:0] stall_cnt
`else
    output logic        ex_valid
`endif
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] LU_STALL = 1'b1;

    logic [0:0] state_q, state_d;
    logic       a1_sel_q, a1_sel_d, a2_sel_q, a2_sel_d;
    logic       b1_sel_q, b1_sel_d, b2_sel_q, b2_sel_d;
    logic       ex_valid_q, ex_valid_d, ex_wen_q, ex_wen_d, ex_is_load_q, ex_is_load_d;
    logic [4:0] ex_rd_q, ex_rd_d;
    logic       wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d, wb_is_load_q, wb_is_load_d;
    logic [4:0] wb_rd_q, wb_rd_d;
    logic       hit1, hit2, load_use, bubble;

    // x0 never forwards, and an empty decode slot never matches.
    always_comb begin
        hit1     = id_valid & id_use_rs1 & ex_valid_q & ex_wen_q & (ex_rd_q != 5'd0) & (id_rs1 == ex_rd_q);
        hit2     = id_valid & id_use_rs2 & ex_valid_q & ex_wen_q & (ex_rd_q != 5'd0) & (id_rs2 == ex_rd_q);
        load_use = id_valid & ex_is_load_q & (hit1 | hit2);
        flush    = br_taken;
        stall    = load_use & ~br_taken & (state_q == RUN);
        bubble   = stall | flush;
        state_d  = (state_q == RUN && stall) ? LU_STALL : RUN;
    end

    // Forward selects are independent of the PC/immediate selects so the branch comparator keeps them.
    always_comb begin
        wb_valid_d   = ex_valid_q;
        wb_wen_d     = ex_wen_q;
        wb_is_load_d = ex_is_load_q;
        wb_rd_d      = ex_rd_q;
        a1_sel_d     = 1'b0;
        a2_sel_d     = 1'b0;
        b1_sel_d     = 1'b0;
        b2_sel_d     = 1'b0;
        ex_valid_d   = 1'b0;
        ex_wen_d     = id_reg_wen;
        ex_is_load_d = id_is_load;
        ex_rd_d      = id_rd;
        if (!bubble) begin
            a1_sel_d   = hit1;
            b1_sel_d   = hit2;
            a2_sel_d   = id_a_pc;
            b2_sel_d   = id_b_imm;
            ex_valid_d = id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            a1_sel_q   <= 1'b0;
            a2_sel_q   <= 1'b0;
            b1_sel_q   <= 1'b0;
            b2_sel_q   <= 1'b0;
            ex_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a1_sel_q     <= a1_sel_d;
            a2_sel_q     <= a2_sel_d;
            b1_sel_q     <= b1_sel_d;
            b2_sel_q     <= b2_sel_d;
            ex_valid_q   <= ex_valid_d;
            ex_wen_q     <= ex_wen_d;
            ex_is_load_q <= ex_is_load_d;
            ex_rd_q      <= ex_rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_wen_q     <= wb_wen_d;
            wb_is_load_q <= wb_is_load_d;
            wb_rd_q      <= wb_rd_d;
        end
    end

    assign A1_sel   = a1_sel_q;
    assign A2_sel   = a2_sel_q;
    assign B1_sel   = b1_sel_q;
    assign B2_sel   = b2_sel_q;
    assign ex_valid = ex_valid_q;

    // The WB entry is kept only for the write-first register file; it must always trail EX by one cycle.
    wb_tracks_ex: assert property (@(posedge clk)
        (!rst && !$past(rst)) |->
        ({wb_valid_q, wb_wen_q, wb_is_load_q, wb_rd_q} == $past({ex_valid_q, ex_wen_q, ex_is_load_q, ex_rd_q})));

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
